// File: rtl/tx_pkt_arbiter.sv
// tx_pkt_arbiter: packet-granular round-robin arbiter that shares the 64-bit
// TX AXI-Stream input of a 10G MAC among NUM_PORTS user streams.
// A grant is held for a whole frame. Frames longer than MAX_BEATS are cut:
// the last forwarded beat carries a forced tlast, and the rest of the frame
// is drained from the requester without being forwarded.
// Optional build macro: TX_ARB_PKT_CNT_EN adds per-port completed-frame
// counters (cnt_clr input, port_pkt_cnt output).
module tx_pkt_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int MAX_BEATS  = 1200,
    parameter int BEAT_CNT_W = 11
) (
    input  logic                    tx_axis_fifo_aclk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    port_en,
    input  logic [NUM_PORTS*64-1:0] s_tdata,
    input  logic [NUM_PORTS*8-1:0]  s_tkeep,
    input  logic [NUM_PORTS-1:0]    s_tvalid,
    input  logic [NUM_PORTS-1:0]    s_tlast,
    output logic [NUM_PORTS-1:0]    s_tready,
    output logic [63:0]             m_tdata,
    output logic [7:0]              m_tkeep,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic                    trunc_err
`ifdef TX_ARB_PKT_CNT_EN
    ,
    input  logic                    cnt_clr,
    output logic [NUM_PORTS*32-1:0] port_pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    logic [2:0]            ptr_r;
    logic [2:0]            grant_id_r;
    logic [BEAT_CNT_W-1:0] beat_cnt_r;
    logic                  busy_r;
    logic                  trunc_err_r;

    logic [NUM_PORTS-1:0]  req_s;
    logic [2:0]            pick_s;
    logic                  found_s;
    logic [63:0]           sel_data_s;
    logic [7:0]            sel_keep_s;
    logic                  sel_valid_s;
    logic                  sel_last_s;
    logic                  at_max_s;
    logic                  accept_s;
    logic                  drain_acc_s;
    logic [NUM_PORTS-1:0]  s_tready_s;
    logic [63:0]           m_tdata_s;
    logic [7:0]            m_tkeep_s;
    logic                  m_tvalid_s;
    logic                  m_tlast_s;

    // Round-robin pick: first requesting port above the pointer, then wrap to the lowest.
    always_comb begin
        req_s   = s_tvalid & port_en;
        pick_s  = 3'd0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pick_s  = (!found_s && req_s[i] && (i > int'(ptr_r))) ? 3'(i) : pick_s;
            found_s = found_s | (req_s[i] && (i > int'(ptr_r)));
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            pick_s  = (!found_s && req_s[i] && (i <= int'(ptr_r))) ? 3'(i) : pick_s;
            found_s = found_s | (req_s[i] && (i <= int'(ptr_r)));
        end
    end

    // Select the granted requester's stream with an AND-OR mux.
    always_comb begin
        sel_data_s  = 64'd0;
        sel_keep_s  = 8'd0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_data_s  = sel_data_s  | (s_tdata[i*64 +: 64] & {64{grant_id_r == 3'(i)}});
            sel_keep_s  = sel_keep_s  | (s_tkeep[i*8 +: 8]   & {8{grant_id_r == 3'(i)}});
            sel_valid_s = sel_valid_s | (s_tvalid[i] & (grant_id_r == 3'(i)));
            sel_last_s  = sel_last_s  | (s_tlast[i]  & (grant_id_r == 3'(i)));
        end
    end

    // Handshake qualifiers and the truncation point (zero-based beat MAX_BEATS-1).
    always_comb begin
        at_max_s    = (beat_cnt_r == BEAT_CNT_W'(MAX_BEATS - 1));
        accept_s    = (state_r == ST_XFER) & sel_valid_s & m_tready;
        drain_acc_s = (state_r == ST_DRAIN) & sel_valid_s;
    end

    // Route ready back to the granted requester only; draining accepts unconditionally.
    always_comb begin
        s_tready_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_tready_s[i] = (grant_id_r == 3'(i)) &
                            (((state_r == ST_XFER) & m_tready) | (state_r == ST_DRAIN));
        end
    end

    // Master side: pass-through while transferring, quiet otherwise.
    always_comb begin
        m_tdata_s  = 64'd0;
        m_tkeep_s  = 8'd0;
        m_tvalid_s = 1'b0;
        m_tlast_s  = 1'b0;
        case (state_r)
            ST_XFER: begin
                m_tdata_s  = sel_data_s;
                m_tkeep_s  = sel_keep_s;
                m_tvalid_s = sel_valid_s;
                m_tlast_s  = sel_last_s | at_max_s;
            end
            default: begin
                m_tdata_s  = 64'd0;
                m_tkeep_s  = 8'd0;
                m_tvalid_s = 1'b0;
                m_tlast_s  = 1'b0;
            end
        endcase
    end

    // Arbiter FSM: grant, frame transfer with truncation, drain of the cut remainder.
    always_ff @(posedge tx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'(NUM_PORTS - 1);
            grant_id_r  <= 3'd0;
            beat_cnt_r  <= {BEAT_CNT_W{1'b0}};
            busy_r      <= 1'b0;
            trunc_err_r <= 1'b0;
        end else begin
            trunc_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r <= pick_s;
                        beat_cnt_r <= {BEAT_CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= ST_XFER;
                    end else begin
                        busy_r     <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (accept_s) begin
                        beat_cnt_r <= (beat_cnt_r == {BEAT_CNT_W{1'b1}}) ?
                                      beat_cnt_r : beat_cnt_r + BEAT_CNT_W'(1);
                        if (sel_last_s) begin
                            ptr_r   <= grant_id_r;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else if (at_max_s) begin
                            trunc_err_r <= 1'b1;
                            state_r     <= ST_DRAIN;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end else begin
                        state_r <= ST_XFER;
                    end
                end
                ST_DRAIN: begin
                    if (drain_acc_s && sel_last_s) begin
                        ptr_r   <= grant_id_r;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TX_ARB_PKT_CNT_EN
    logic        frame_end_s;
    logic [31:0] pkt_cnt_r [NUM_PORTS];

    // A frame ends on the forwarded beat that carries tlast, natural or forced.
    always_comb begin
        frame_end_s = accept_s & m_tlast_s;
    end

    // Per-port completed-frame counters; clear wins over a same-cycle increment.
    always_ff @(posedge tx_axis_fifo_aclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_r[i] <= 32'd0;
            end
        end else if (cnt_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                pkt_cnt_r[i] <= (frame_end_s && (grant_id_r == 3'(i))) ?
                                pkt_cnt_r[i] + 32'd1 : pkt_cnt_r[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt_out
        assign port_pkt_cnt[g*32 +: 32] = pkt_cnt_r[g];
    end
`else
    // Frame counters are not built in this configuration.
`endif

    assign s_tready  = s_tready_s;
    assign m_tdata   = m_tdata_s;
    assign m_tkeep   = m_tkeep_s;
    assign m_tvalid  = m_tvalid_s;
    assign m_tlast   = m_tlast_s;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;
    assign trunc_err = trunc_err_r;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Testbench for tx_pkt_arbiter: random frames from all ports, a frame-level
// reference model that pushes expected output beats into a scoreboard queue,
// and a separate monitor that pops and compares every accepted output beat.
module tb_tx_pkt_arbiter;
    localparam int NP = 4;
    localparam int MB = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NP-1:0]   port_en;
    logic [NP*64-1:0] s_tdata;
    logic [NP*8-1:0] s_tkeep;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tlast;
    logic [NP-1:0]   s_tready;
    logic [63:0]     m_tdata;
    logic [7:0]      m_tkeep;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [2:0]      grant_id;
    logic            busy;
    logic            trunc_err;

    tx_pkt_arbiter #(.NUM_PORTS(NP), .MAX_BEATS(MB), .BEAT_CNT_W(CW)) dut (
        .tx_axis_fifo_aclk(clk), .reset(reset), .port_en(port_en),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .grant_id(grant_id), .busy(busy),
        .trunc_err(trunc_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    beat_t src_q [NP][$];
    beat_t exp_q [$];
    int    frame_no = 0;

    // stimulus knobs
    logic [NP-1:0] vld_mask;
    int            vld_pct;
    int            rdy_pct;
    bit            en_rand;
    logic [NP-1:0] fire_r;

    // reference model state: frame-level view of the arbiter
    bit m_busy = 1'b0;
    int m_port = 0;
    int m_last = 0;
    int m_ptr  = NP - 1;
    int m_cons = 0;
    int m_len  = 0;
    bit trunc_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic gen_frame(input int p, input int len, input logic [7:0] last_keep);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(p), 16'(frame_no), 8'(i), 32'($urandom)};
            b.keep = (i == len - 1) ?
                     ((last_keep != 8'h00) ? last_keep : 8'($urandom_range(1, 255))) : 8'hFF;
            b.last = (i == len - 1);
            src_q[p].push_back(b);
        end
        frame_no++;
    endtask

    // Pop consumed beats, refill empty ports with a new frame, randomise valid/ready.
    task automatic drive_update();
        beat_t tmp;
        for (int p = 0; p < NP; p++) begin
            if (fire_r[p]) tmp = src_q[p].pop_front();
            if (src_q[p].size() == 0) gen_frame(p, $urandom_range(1, 7), 8'h00);
            s_tdata[p*64 +: 64] = src_q[p][0].data;
            s_tkeep[p*8 +: 8]   = src_q[p][0].keep;
            s_tlast[p]          = src_q[p][0].last;
            s_tvalid[p]         = vld_mask[p] && ($urandom_range(0, 99) < vld_pct);
        end
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        if (en_rand && ($urandom_range(0, 9) == 0))
            port_en = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        fire_r = '0;
    endtask

    // One model step, evaluated on the negedge with inputs stable for the next posedge.
    task automatic model_step();
        logic [NP-1:0] req;
        logic [NP-1:0] exp_rdy;
        int p;
        beat_t e;
        exp_rdy = '0;
        chk("trunc_err", 64'(trunc_err), 64'(trunc_pend));
        trunc_pend = 1'b0;
        if (!m_busy) begin
            chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_grant_id", 64'(grant_id), 64'(m_last));
            chk("idle_s_tready", 64'(s_tready), 64'd0);
            req = s_tvalid & port_en;
            p = -1;
            for (int k = 1; k <= NP; k++) begin
                int idx;
                idx = (m_ptr + k) % NP;
                if (p < 0 && req[idx]) p = idx;
            end
            if (p >= 0) begin
                m_len = src_q[p].size();
                for (int b = 0; b < m_len && b < MB; b++) begin
                    e = src_q[p][b];
                    if (b == MB - 1) e.last = 1'b1;
                    exp_q.push_back(e);
                end
                m_busy = 1'b1;
                m_port = p;
                m_last = p;
                m_cons = 0;
            end
        end else begin
            chk("busy", 64'(busy), 64'd1);
            chk("grant_id", 64'(grant_id), 64'(m_port));
            if (m_cons < MB) begin
                exp_rdy[m_port] = m_tready;
                chk("xfer_m_tvalid", 64'(m_tvalid), 64'(s_tvalid[m_port]));
            end else begin
                exp_rdy[m_port] = 1'b1;
                chk("drain_m_tvalid", 64'(m_tvalid), 64'd0);
            end
            chk("s_tready", 64'(s_tready), 64'(exp_rdy));
            if (s_tvalid[m_port] && exp_rdy[m_port]) begin
                fire_r[m_port] = 1'b1;
                if (m_cons == MB - 1 && m_len > MB) trunc_pend = 1'b1;
                m_cons++;
                if (m_cons == m_len) begin
                    m_busy = 1'b0;
                    m_ptr  = m_port;
                end
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (!reset) model_step();
            @(posedge clk);
            #1;
            drive_update();
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        port_en  = '0;
        en_rand  = 1'b0;
        vld_mask = 4'hF;
        vld_pct  = 100;
        rdy_pct  = 100;
        c = 0;
        while (m_busy && c < budget) begin
            run_cycles(1);
            c++;
        end
        total++;
        if (m_busy) begin
            bad++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", budget);
        end
        run_cycles(2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every beat accepted by the MAC must match the next expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_tdata, e.data);
                chk("beat_keep", 64'(m_tkeep), 64'(e.keep));
                chk("beat_last", 64'(m_tlast), 64'(e.last));
            end
        end
    end

    initial begin
        port_en  = 4'hF;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        fire_r   = '0;
        en_rand  = 1'b0;
        gen_frame(0, 3, 8'h0F);
        for (int p = 1; p < NP; p++) gen_frame(p, 2, 8'h00);

        #1 reset = 1'b1;
        #3;
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_trunc_err", 64'(trunc_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // port 0 alone: 3-beat frame, keep FF,FF,0F
        vld_mask = 4'b0001; vld_pct = 100; rdy_pct = 100;
        drive_update();
        run_cycles(8);

        // all ports valid: round robin with one bubble between frames
        vld_mask = 4'hF;
        run_cycles(40);

        // port 2 disabled, ports 2 and 3 requesting
        port_en = 4'b1011; vld_mask = 4'b1100;
        run_cycles(30);

        // fully random traffic, backpressure and enables
        port_en = 4'hF; vld_mask = 4'hF; vld_pct = 75; rdy_pct = 60; en_rand = 1'b1;
        run_cycles(2000);
        wait_idle(300);

        // reset in the middle of a frame from port 0
        port_en = 4'hF; vld_mask = 4'b0001; vld_pct = 100; rdy_pct = 100;
        for (int c = 0; c < 50 && !(m_busy && m_cons >= 1); c++) run_cycles(1);
        total++;
        if (!(m_busy && m_cons >= 1)) begin
            bad++;
            $display("FAIL midframe_setup: got no frame in progress expected one");
        end
        #1 reset = 1'b1;
        #1;
        chk("async_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("async_s_tready", 64'(s_tready), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_grant_id", 64'(grant_id), 64'd0);
        m_busy = 1'b0; m_ptr = NP - 1; m_last = 0; m_cons = 0; trunc_pend = 1'b0;
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            gen_frame(p, $urandom_range(1, 7), 8'h00);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        vld_mask = 4'hF;
        fire_r = '0;
        drive_update();
        run_cycles(1);
        chk("post_rst_grant_port0", 64'(m_port), 64'd0);
        run_cycles(60);
        wait_idle(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single 64-bit TX AXI-Stream input of a 10G Ethernet MAC port among NUM_PORTS user streams.
- Sits between the switch egress queues and the MAC's TX FIFO interface, in the TX FIFO clock domain.
- Holds a grant for a whole frame, so frames are never interleaved.
- Truncates runaway frames longer than MAX_BEATS and drains their remainder.

Parameters:
- NUM_PORTS, 4, number of requesting streams (2..8).
- MAX_BEATS, 1200, maximum beats per frame before forced truncation (9600 B jumbo at 8 B/beat).
- BEAT_CNT_W, 11, width of the beat counter; must satisfy 2^BEAT_CNT_W > MAX_BEATS.

Ports:
- tx_axis_fifo_aclk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- port_en  in  NUM_PORTS  per-port grant enable; a port with its bit at 0 is never newly granted.
- s_tdata  in  NUM_PORTS*64  packed requester data; port i occupies [64i+63:64i].
- s_tkeep  in  NUM_PORTS*8  packed byte enables.
- s_tvalid  in  NUM_PORTS  requester valid.
- s_tlast  in  NUM_PORTS  requester end of frame.
- s_tready  out  NUM_PORTS  requester ready.
- m_tdata  out  64  to MAC tx_axis_fifo_tdata.
- m_tkeep  out  8  to MAC tx_axis_fifo_tkeep.
- m_tvalid  out  1  to MAC tx_axis_fifo_tvalid.
- m_tlast  out  1  to MAC tx_axis_fifo_tlast.
- m_tready  in  1  from MAC tx_axis_fifo_tready.
- grant_id  out  3  index of the current or most recent granted port.
- busy  out  1  high while in XFER or DRAIN.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset values: state IDLE; s_tready 0; m_tvalid 0; m_tlast 0; m_tdata 0; m_tkeep 0; grant_id 0; busy 0; trunc_err 0. The RR pointer is reset to NUM_PORTS-1, so port 0 has first priority.
- States:
  - IDLE: on the first cycle in which req = s_tvalid & port_en is non-zero, select the first set bit searching upward from pointer+1 with wrap. Register grant_id, clear the beat counter, go to XFER. Arbitration latency is 1 cycle and there is no output beat during IDLE.
  - XFER:
    - Connection is combinational pass-through: m_* = s_*[grant_id], s_tready[grant_id] = m_tready, all other s_tready = 0.
    - The beat counter increments on each m_tvalid & m_tready.
    - On an accepted beat with s_tlast: pointer <= grant_id, go to IDLE. This gives exactly one bubble cycle between frames.
    - On the accepted beat where the count reaches MAX_BEATS-1 without s_tlast: force m_tlast = 1 on that beat, pulse trunc_err the next cycle, go to DRAIN.
  - DRAIN: m_tvalid = 0; s_tready[grant_id] = 1. Discard beats until an s_tlast beat is accepted, then pointer <= grant_id and go to IDLE.
- Timing rules:
  - m_tvalid never asserts in IDLE.
  - Clearing port_en mid-frame does not abort the frame; it only blocks the next grant.
  - A requester deasserting s_tvalid mid-frame stalls the output, with no timeout.
  - Requesters whose s_tvalid rises in the same cycle are resolved by pointer order only.
- Boundary cases:
  - A single-beat frame (s_tlast on the first beat) takes 1 cycle in XFER.
  - Beat MAX_BEATS-1 carrying s_tlast is a normal end and is not truncated.
  - With a single requester continuously valid, the same port is re-granted after one IDLE cycle.
  - The beat counter saturates and cannot wrap.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The downstream MAC FIFO is expected to be reset by the same reset.

Optional Feature:
- Macro: TX_ARB_PKT_CNT_EN.
- When defined:
  - Adds input cnt_clr (1) and output port_pkt_cnt (NUM_PORTS*32).
  - Per-port 32-bit counters of completed frames (normal or truncated) increment on the frame-ending accepted beat.
  - Counters wrap modulo 2^32.
  - cnt_clr synchronously zeroes all counters and has priority over a same-cycle increment.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, port 0 sends a 3-beat frame (tkeep FF,FF,0F), m_tready=1 → m_tvalid asserts the cycle after the IDLE grant. 3 beats appear in order with m_tlast on beat 3 and tkeep 0F. grant_id=0.
- Ports 0–3 all continuously valid with 2-beat frames → grant order 0,1,2,3,0,… with one idle cycle between frames; no interleaving.
- port_en=4'b1011, ports 2 and 3 valid → only port 3 is granted; port 2's s_tready stays 0.
- m_tready toggles 1,0,1,0 during a 5-beat frame from port 1 → all 5 beats delivered unmodified; s_tready[1] mirrors m_tready.
- MAX_BEATS=4, port 2 sends a 7-beat frame → 4 output beats with m_tlast on beat 4. trunc_err pulses once; beats 5–7 are consumed with m_tvalid=0. Next grant goes to port 3.
- Reset asserted on beat 2 of a frame → m_tvalid and s_tready go to 0 asynchronously; after release, port 0 has priority.
